baccarat_round_ctrl: RTL and testbench

Parametrised round controller for the baccarat datapath. It sequences the four initial deals and the third-card rules, and gates every card load on a card-valid handshake from the dealing logic. It latches the win/tie result, pulses the balance update once per round, and holds the result for a configurable time. It then returns to betting, or locks out when the balance is exhausted.

---
 rtl/baccarat_round_ctrl.sv | 170 +++++++++++++++++
 tb/tb_baccarat_round_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/baccarat_round_ctrl.sv
// Baccarat round sequencer: four initial deals, third-card rules, settlement, result hold and lockout.
// Optional completed-round counter is compiled in when ROUND_COUNT_EN is defined.
module baccarat_round_ctrl #(
  parameter int BAL_W       = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int RND_W       = 8
) (
  input  logic             slow_clock,
  input  logic             resetb,
  input  logic             start,
  input  logic             card_valid,
  input  logic [3:0]       pscore,
  input  logic [3:0]       dscore,
  input  logic [3:0]       pcard3,
  input  logic [BAL_W-1:0] balance,
  output logic             load_pcard1,
  output logic             load_pcard2,
  output logic             load_pcard3,
  output logic             load_dcard1,
  output logic             load_dcard2,
  output logic             load_dcard3,
  output logic             player_win_light,
  output logic             dealer_win_light,
  output logic             betenabled,
  output logic             updatebalanceenable,
  output logic             busy
`ifdef ROUND_COUNT_EN
  ,
  output logic [RND_W-1:0] round_count
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_P1, S_D1, S_P2, S_D2, S_CHECK,
    S_P3, S_DEC3, S_D3, S_SETTLE, S_HOLD, S_BROKE
  } state_t;

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);

  state_t          state_q, state_d;
  logic [HC_W-1:0] hold_q, hold_d;
  logic            plight_q, plight_d;
  logic            dlight_q, dlight_d;
  logic            dealer_draw;

  // Banker tableau once the player's third card is known.
  always_comb begin
    dealer_draw = 1'b0;
    if (pcard3 == 4'd9)
      dealer_draw = (dscore <= 4'd3);
    else if (pcard3 == 4'd8)
      dealer_draw = (dscore <= 4'd2);
    else if (pcard3 <= 4'd7)
      dealer_draw = (dscore <= ({1'b0, pcard3[3:1]} + 4'd3));
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      plight_q <= 1'b0;
      dlight_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      plight_q <= plight_d;
      dlight_q <= dlight_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    hold_d              = hold_q;
    plight_d            = plight_q;
    dlight_d            = dlight_q;
    load_pcard1         = 1'b0;
    load_pcard2         = 1'b0;
    load_pcard3         = 1'b0;
    load_dcard1         = 1'b0;
    load_dcard2         = 1'b0;
    load_dcard3         = 1'b0;
    betenabled          = 1'b0;
    updatebalanceenable = 1'b0;
    busy                = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy       = 1'b0;
        betenabled = 1'b1;
        if (start) begin
          state_d  = S_P1;
          plight_d = 1'b0;
          dlight_d = 1'b0;
        end
      end
      S_P1: begin
        load_pcard1 = card_valid;
        if (card_valid) state_d = S_D1;
      end
      S_D1: begin
        load_dcard1 = card_valid;
        if (card_valid) state_d = S_P2;
      end
      S_P2: begin
        load_pcard2 = card_valid;
        if (card_valid) state_d = S_D2;
      end
      S_D2: begin
        load_dcard2 = card_valid;
        if (card_valid) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (pscore >= 4'd8 || dscore >= 4'd8) state_d = S_SETTLE;
        else if (pscore <= 4'd5)              state_d = S_P3;
        else if (dscore <= 4'd5)              state_d = S_D3;
        else                                  state_d = S_SETTLE;
      end
      S_P3: begin
        load_pcard3 = card_valid;
        if (card_valid) state_d = S_DEC3;
      end
      S_DEC3: begin
        state_d = dealer_draw ? S_D3 : S_SETTLE;
      end
      S_D3: begin
        load_dcard3 = card_valid;
        if (card_valid) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        // Tie lights both lamps.
        updatebalanceenable = 1'b1;
        plight_d            = (pscore >= dscore);
        dlight_d            = (dscore >= pscore);
        hold_d              = HOLD_LOAD;
        state_d             = S_HOLD;
      end
      S_HOLD: begin
        if (hold_q == '0) state_d = (balance == '0) ? S_BROKE : S_IDLE;
        else              hold_d  = hold_q - HC_W'(1);
      end
      S_BROKE: begin
        busy = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign player_win_light = plight_q;
  assign dealer_win_light = dlight_q;

`ifdef ROUND_COUNT_EN
  logic [RND_W-1:0] rnd_q, rnd_d;

  always_comb begin
    rnd_d = rnd_q;
    if (state_q == S_SETTLE && rnd_q != '1) rnd_d = rnd_q + RND_W'(1);
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) rnd_q <= '0;
    else         rnd_q <= rnd_d;
  end

  assign round_count = rnd_q;
`else
  if (RND_W < 1) begin : g_no_round_count
  end
`endif

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Self-checking bench for baccarat_round_ctrl: table of rounds with a settlement scoreboard,
// plus hand-written broke-lockout and mid-round reset sequences.
module tb_baccarat_round_ctrl;
  localparam int BAL_W = 8;
  localparam int HOLD  = 2;
  localparam int RND_W = 8;

  logic             slow_clock, resetb, start, card_valid;
  logic [3:0]       pscore, dscore, pcard3;
  logic [BAL_W-1:0] balance;
  logic             load_pcard1, load_pcard2, load_pcard3;
  logic             load_dcard1, load_dcard2, load_dcard3;
  logic             player_win_light, dealer_win_light;
  logic             betenabled, updatebalanceenable, busy;
`ifdef ROUND_COUNT_EN
  logic [RND_W-1:0] round_count;
`endif

  baccarat_round_ctrl #(.BAL_W(BAL_W), .HOLD_CYCLES(HOLD), .RND_W(RND_W)) dut (
    .slow_clock(slow_clock), .resetb(resetb), .start(start), .card_valid(card_valid),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3), .balance(balance),
    .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
    .player_win_light(player_win_light), .dealer_win_light(dealer_win_light),
    .betenabled(betenabled), .updatebalanceenable(updatebalanceenable), .busy(busy)
`ifdef ROUND_COUNT_EN
    , .round_count(round_count)
`endif
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  typedef struct {
    int p_chk; int d_chk; int pc3; int p_fin; int d_fin; int bal; int stall;
    int exp_p3; int exp_d3; int exp_settle; int exp_d1; int exp_lights;
  } vec_t;

  vec_t vecs[14];
  vec_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int lights();
    return {30'd0, player_win_light, dealer_win_light};
  endfunction

  function automatic int loads();
    return {26'd0, load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3};
  endfunction

  task automatic play(input int idx);
    vec_t v, e;
    int settle_at, strobes, n_p3, n_d3, n_base, d1_at, hold_len;
    bit done;
    v = vecs[idx];
    settle_at = -1; strobes = 0; n_p3 = 0; n_d3 = 0; n_base = 0; d1_at = -1; hold_len = 0;
    done = 1'b0;
    pscore = 4'(v.p_chk); dscore = 4'(v.d_chk); pcard3 = 4'(v.pc3);
    balance = BAL_W'(v.bal); card_valid = 1'b1; start = 1'b1;
    sb_q.push_back(v);
    @(posedge slow_clock);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      #1;
      start = 1'b0;
      card_valid = !(v.stall > 0 && cyc >= 2 && cyc < 2 + v.stall);
      @(negedge slow_clock);
      if (cyc == 1) chk("lights_clear", lights(), 0);
      n_base += int'(load_pcard1) + int'(load_dcard1) + int'(load_pcard2) + int'(load_dcard2);
      n_p3 += int'(load_pcard3);
      n_d3 += int'(load_dcard3);
      if (load_dcard1) d1_at = cyc;
      if (updatebalanceenable) begin
        strobes++;
        if (settle_at < 0) begin
          settle_at = cyc;
          if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
            e = v;
          end else begin
            e = sb_q.pop_front();
          end
          chk("settle_cycle", cyc, e.exp_settle);
          pscore = 4'(e.p_fin);
          dscore = 4'(e.d_fin);
        end
      end else if (settle_at >= 0) begin
        if (cyc == settle_at + 1) chk("lights", lights(), e.exp_lights);
        if (busy) hold_len++;
        else begin
          done = 1'b1;
          break;
        end
      end
      @(posedge slow_clock);
    end
    if (!done || settle_at < 0) begin
      chk("round_timeout", 0, 1);
    end else begin
      chk("strobe_count", strobes, 1);
      chk("base_loads", n_base, 4);
      chk("dcard1_cycle", d1_at, e.exp_d1);
      chk("pcard3_loads", n_p3, e.exp_p3);
      chk("dcard3_loads", n_d3, e.exp_d3);
      chk("hold_len", hold_len, HOLD);
      chk("end_betenabled", int'(betenabled), (e.bal != 0) ? 1 : 0);
    end
    $display("round %0d: p=%0d d=%0d pc3=%0d settle@%0d p3=%0d d3=%0d lights=%b",
             idx, v.p_chk, v.d_chk, v.pc3, settle_at, n_p3, n_d3, lights() & 3);
  endtask

  initial begin
    int strobes;
    //            p  d pc3 pf df bal st p3 d3 set d1 lights
    vecs[0]  = '{8, 3, 0, 8, 3, 5, 0, 0, 0, 6,  2, 2};  // player natural
    vecs[1]  = '{4, 5, 5, 7, 7, 5, 0, 1, 1, 9,  2, 3};  // both draw, tie
    vecs[2]  = '{2, 2, 8, 2, 2, 5, 0, 1, 1, 9,  2, 3};  // pcard3=8, dscore 2 draws
    vecs[3]  = '{2, 3, 8, 2, 3, 5, 0, 1, 0, 8,  2, 1};  // pcard3=8, dscore 3 stands
    vecs[4]  = '{6, 4, 0, 6, 7, 5, 0, 0, 1, 7,  2, 1};  // dealer-only draw
    vecs[5]  = '{7, 6, 0, 7, 6, 5, 0, 0, 0, 6,  2, 2};  // both stand
    vecs[6]  = '{5, 3, 9, 4, 3, 5, 0, 1, 1, 9,  2, 2};  // pcard3=9, dscore 3 draws
    vecs[7]  = '{5, 4, 9, 4, 4, 5, 0, 1, 0, 8,  2, 3};  // pcard3=9, dscore 4 stands
    vecs[8]  = '{1, 9, 0, 1, 9, 5, 0, 0, 0, 6,  2, 1};  // dealer natural
    vecs[9]  = '{0, 3, 0, 0, 5, 5, 0, 1, 1, 9,  2, 1};  // pcard3=0 limit 3
    vecs[10] = '{3, 6, 7, 0, 6, 5, 0, 1, 1, 9,  2, 1};  // pcard3=7 limit 6
    vecs[11] = '{5, 7, 6, 1, 7, 5, 0, 1, 0, 8,  2, 1};  // pcard3=6, dscore 7 stands
    vecs[12] = '{4, 5, 5, 7, 7, 5, 3, 1, 1, 12, 5, 3};  // 3-cycle stall in D1
    vecs[13] = '{8, 8, 0, 8, 8, 0, 0, 0, 0, 6,  2, 3};  // tie natural, balance 0

    resetb = 1'b0; start = 1'b0; card_valid = 1'b0;
    pscore = '0; dscore = '0; pcard3 = '0; balance = '0;
    repeat (2) @(posedge slow_clock);
    @(negedge slow_clock);
    chk("reset_outputs", {betenabled, busy, loads()[5:0], updatebalanceenable, lights()[1:0]},
        11'b1_0_000000_0_00);
    @(posedge slow_clock);
    #1 resetb = 1'b1;
    @(negedge slow_clock);
    chk("idle_betenabled", int'(betenabled), 1);

    for (int i = 0; i < 14; i++) play(i);

`ifdef ROUND_COUNT_EN
    chk("round_count", int'(round_count), (14 > (2**RND_W - 1)) ? (2**RND_W - 1) : 14);
`endif

    // Locked out: start is ignored and the last result stays lit.
    start = 1'b1;
    repeat (4) begin
      @(negedge slow_clock);
      chk("broke_idle", {busy, betenabled, loads()[5:0]}, 0);
    end
    chk("broke_lights", lights(), 3);
    #1 resetb = 1'b0;
    #1;
    chk("broke_reset", {betenabled, busy, lights()[1:0]}, 4'b1000);
    @(posedge slow_clock);
    #1 resetb = 1'b1; start = 1'b0;
    $display("broke sequence done");

    // Reset during P2 abandons the round.
    pscore = 4'd8; dscore = 4'd3; balance = 8'd5; card_valid = 1'b1; start = 1'b1;
    @(negedge slow_clock);
    @(posedge slow_clock);
    #1 start = 1'b0;
    repeat (2) @(posedge slow_clock);
    @(negedge slow_clock);
    chk("midround_p2_load", loads(), 6'b001000);
    #1 resetb = 1'b0;
    #1;
    chk("midround_reset", {betenabled, busy, lights()[1:0]}, 4'b1000);
`ifdef ROUND_COUNT_EN
    chk("round_count_reset", int'(round_count), 0);
`endif
    @(posedge slow_clock);
    #1 resetb = 1'b1;
    strobes = 0;
    repeat (10) begin
      @(negedge slow_clock);
      strobes += int'(updatebalanceenable) + int'(busy);
    end
    chk("midround_no_strobe", strobes, 0);
    chk("midround_idle", int'(betenabled), 1);
    $display("midround reset sequence done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
